// File: rtl/pool_feed_if.sv
// pool_feed_if: configuration, upstream, pool-side and downstream signals of pool_feed.
interface pool_feed_if #(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 8
);
    logic [CNT_WIDTH-1:0] cfg_size;
    logic [CNT_WIDTH-1:0] cfg_windows;
    logic                 cfg_valid;
    logic [NUM_WIDTH-1:0] up_data;
    logic                 up_valid;
    logic                 up_ready;
    logic [NUM_WIDTH-1:0] pool_data;
    logic                 pool_valid;
    logic                 pool_restart;
    logic [NUM_WIDTH-1:0] pool_result;
    logic [NUM_WIDTH-1:0] dn_data;
    logic                 dn_valid;
    logic                 dn_ready;
    logic                 done;

    modport master (
        output cfg_size, cfg_windows, cfg_valid, up_data, up_valid, pool_result, dn_ready,
        input  up_ready, pool_data, pool_valid, pool_restart, dn_data, dn_valid, done
    );

    modport slave (
        input  cfg_size, cfg_windows, cfg_valid, up_data, up_valid, pool_result, dn_ready,
        output up_ready, pool_data, pool_valid, pool_restart, dn_data, dn_valid, done
    );
endinterface

// File: rtl/pool_feed.sv
// pool_feed: windows a stream into the pool stage and collects each window maximum
// into a 2-entry credit-protected output FIFO.
module pool_feed #(
    parameter int NUM_WIDTH = 16,
    parameter int CNT_WIDTH = 8,
    parameter int POOL_LAT  = 4
) (
    input logic       clk,
    input logic       rst,
    pool_feed_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] size_m1;
    logic [CNT_WIDTH-1:0] win_last;
    logic [CNT_WIDTH-1:0] elem;
    logic [CNT_WIDTH-1:0] win;
    logic [POOL_LAT:0]    sr;
    logic [NUM_WIDTH-1:0] mem [2];
    logic                 rd;
    logic                 wr;
    logic [1:0]           cnt;
    logic [3:0]           used;
    logic                 is_last;
    logic                 xfer;
    logic                 push;
    logic                 pop;

    // A last element may only enter when a FIFO slot is reserved for its result.
    assign is_last      = elem == size_m1;
    assign used         = 4'(cnt) + 4'($countones(sr));
    assign bus.up_ready = state == RUN && !(is_last && used >= 4'd2);
    assign xfer         = bus.up_valid && bus.up_ready;
    assign push         = sr[POOL_LAT];
    assign pop          = bus.dn_valid && bus.dn_ready;
    assign bus.dn_valid = cnt != 2'd0;
    assign bus.dn_data  = mem[rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            size_m1          <= '0;
            win_last         <= '0;
            elem             <= '0;
            win              <= '0;
            sr               <= '0;
            mem[0]           <= '0;
            mem[1]           <= '0;
            rd               <= 1'b0;
            wr               <= 1'b0;
            cnt              <= 2'd0;
            bus.pool_data    <= '0;
            bus.pool_valid   <= 1'b0;
            bus.pool_restart <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.pool_valid   <= xfer;
            bus.pool_restart <= xfer && elem == '0;
            if (xfer)
                bus.pool_data <= bus.up_data;
            sr       <= {sr[POOL_LAT-1:0], xfer && is_last};
            bus.done <= 1'b0;
            if (push) begin
                mem[wr] <= bus.pool_result;
                wr      <= !wr;
            end
            if (pop)
                rd <= !rd;
            cnt <= cnt + 2'(push) - 2'(pop);
            if (push && !pop)
                assert (cnt != 2'd2);
            if (state == IDLE && bus.cfg_valid && !bus.done) begin
                size_m1  <= bus.cfg_size == '0 ? '0 : bus.cfg_size - 1'b1;
                win_last <= bus.cfg_windows == '0 ? '0 : bus.cfg_windows - 1'b1;
                elem     <= '0;
                win      <= '0;
                state    <= RUN;
            end
            if (xfer) begin
                elem <= is_last ? '0 : elem + 1'b1;
                if (is_last) begin
                    win <= win + 1'b1;
                    if (win == win_last)
                        state <= DRAIN;
                end
            end
            if (state == DRAIN && pop && cnt == 2'd1 && sr == '0) begin
                state    <= IDLE;
                bus.done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pool_feed.sv
// tb_pool_feed: directed checks of pool_feed paired with a behavioural 4-cycle pool model.
module tb_pool_feed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool_feed_if #(.NUM_WIDTH(16), .CNT_WIDTH(8)) bus ();
    pool_feed #(.NUM_WIDTH(16), .CNT_WIDTH(8), .POOL_LAT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // pool stand-in: running max, restarted by restart, visible 4 cycles after pool_valid
    logic signed [15:0] pmax = '0;
    logic [15:0] pd0 = '0, pd1 = '0, pd2 = '0;
    always @(posedge clk) begin
        if (bus.pool_valid)
            pmax <= (bus.pool_restart || $signed(bus.pool_data) > pmax) ? $signed(bus.pool_data) : pmax;
        pd0 <= pmax;
        pd1 <= pd0;
        pd2 <= pd1;
    end
    assign bus.pool_result = pd2;

    logic [15:0] res_q[$];
    int acc_cyc[$];
    int done_cnt = 0;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dn_valid && bus.dn_ready) res_q.push_back(bus.dn_data);
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.up_valid && bus.up_ready) acc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] s, input logic [7:0] w);
        tick;
        bus.cfg_size    = s;
        bus.cfg_windows = w;
        bus.cfg_valid   = 1'b1;
        tick;
        bus.cfg_valid   = 1'b0;
    endtask

    task automatic send(input logic [15:0] v);
        int n = 0;
        bus.up_data  = v;
        bus.up_valid = 1'b1;
        while (!bus.up_ready && n < 100) begin
            tick;
            n++;
        end
        check("send_ready", 32'(bus.up_ready), 32'd1);
        tick;
    endtask

    task automatic wait_done;
        int n = 0;
        while (!bus.done && n < 200) begin
            tick;
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] vals [5];
        int k;
        vals = '{16'd11, 16'd22, 16'd33, 16'd44, 16'd55};
        bus.cfg_size = '0; bus.cfg_windows = '0; bus.cfg_valid = 1'b0;
        bus.up_data = '0; bus.up_valid = 1'b0; bus.dn_ready = 1'b1;
        tick;
        tick;
        check("rst_up_ready", 32'(bus.up_ready), 32'd0);
        check("rst_pool_valid", 32'(bus.pool_valid), 32'd0);
        check("rst_dn_valid", 32'(bus.dn_valid), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // basic windows
        start(8'd4, 8'd2);
        check("run_ready", 32'(bus.up_ready), 32'd1);
        send(16'd3);
        check("pv_first", 32'(bus.pool_valid), 32'd1);
        check("restart_first", 32'(bus.pool_restart), 32'd1);
        check("pd_first", 32'(bus.pool_data), 32'd3);
        send(16'd9);
        check("restart_mid", 32'(bus.pool_restart), 32'd0);
        send(-16'sd2);
        send(16'd5);
        bus.up_valid = 1'b0;
        tick;
        check("pv_idle", 32'(bus.pool_valid), 32'd0);
        check("pd_hold", 32'(bus.pool_data), 32'd5);
        tick; tick; tick;
        check("dn_early", 32'(bus.dn_valid), 32'd0);
        tick;
        check("dn_latency", 32'(bus.dn_valid), 32'd1);
        check("dn_w0", 32'(bus.dn_data), 32'd9);
        send(16'd1); send(16'd1); send(16'd7); send(16'd0);
        bus.up_valid = 1'b0;
        wait_done;
        bus.cfg_valid = 1'b1;
        tick;
        bus.cfg_valid = 1'b0;
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("cfg_in_done_ignored", 32'(bus.up_ready), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("basic_count", 32'(res_q.size()), 32'd2);
        check("basic_r0", 32'(res_q[0]), 32'd9);
        check("basic_r1", 32'(res_q[1]), 32'd7);

        // negative values
        res_q.delete();
        start(8'd3, 8'd1);
        send(-16'sd5);
        check("neg_restart0", 32'(bus.pool_restart), 32'd1);
        check("neg_pd0", 32'(bus.pool_data), 32'h0000fffb);
        send(-16'sd1);
        check("neg_restart1", 32'(bus.pool_restart), 32'd0);
        send(-16'sd8);
        check("neg_restart2", 32'(bus.pool_restart), 32'd0);
        bus.up_valid = 1'b0;
        wait_done;
        check("neg_count", 32'(res_q.size()), 32'd1);
        check("neg_result", 32'(res_q[0]), 32'h0000ffff);

        // back-pressure
        res_q.delete();
        bus.dn_ready = 1'b0;
        start(8'd1, 8'd5);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            bus.up_data  = vals[k < 5 ? k : 4];
            bus.up_valid = 1'b1;
            if (bus.up_ready) k++;
            tick;
        end
        check("bp_accepted", 32'(k), 32'd2);
        check("bp_ready_low", 32'(bus.up_ready), 32'd0);
        check("bp_dn_valid", 32'(bus.dn_valid), 32'd1);
        check("bp_head_stable", 32'(bus.dn_data), 32'd11);
        bus.dn_ready = 1'b1;
        while (k < 5) begin
            send(vals[k]);
            k++;
        end
        bus.up_valid = 1'b0;
        wait_done;
        check("bp_count", 32'(res_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("bp_order", 32'(res_q[i]), 32'(vals[i]));

        // zero configuration
        res_q.delete();
        start(8'd0, 8'd0);
        send(16'd42);
        bus.up_valid = 1'b0;
        wait_done;
        check("zero_count", 32'(res_q.size()), 32'd1);
        check("zero_result", 32'(res_q[0]), 32'd42);

        // reset mid-window
        start(8'd4, 8'd1);
        send(16'd100);
        send(16'd50);
        bus.up_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_up_ready", 32'(bus.up_ready), 32'd0);
        check("mid_rst_pool_valid", 32'(bus.pool_valid), 32'd0);
        check("mid_rst_pool_restart", 32'(bus.pool_restart), 32'd0);
        check("mid_rst_pool_data", 32'(bus.pool_data), 32'd0);
        check("mid_rst_dn_valid", 32'(bus.dn_valid), 32'd0);
        check("mid_rst_dn_data", 32'(bus.dn_data), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        tick;
        tick;
        rst = 1'b0;
        res_q.delete();
        start(8'd2, 8'd1);
        send(16'd4);
        send(16'd6);
        bus.up_valid = 1'b0;
        wait_done;
        check("rst_job_count", 32'(res_q.size()), 32'd1);
        check("rst_job_result", 32'(res_q[0]), 32'd6);

        // back-to-back windows
        res_q.delete();
        acc_cyc.delete();
        start(8'd2, 8'd3);
        for (int v = 1; v <= 6; v++)
            send(16'(v));
        bus.up_valid = 1'b0;
        wait_done;
        check("b2b_transfers", 32'(acc_cyc.size()), 32'd6);
        check("b2b_gapless", 32'(acc_cyc[4] - acc_cyc[0]), 32'd4);
        check("b2b_count", 32'(res_q.size()), 32'd3);
        check("b2b_r0", 32'(res_q[0]), 32'd2);
        check("b2b_r1", 32'(res_q[1]), 32'd4);
        check("b2b_r2", 32'(res_q[2]), 32'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
